set_job_sequencer: RTL and testbench

Upstream/downstream wrapper for the SET circle-counting engine. Accepts jobs (central, radius, mode, tag) from a host over valid/ready and buffers them in a small FIFO. Issues each job to SET as a single-cycle `en` pulse, honouring `busy`. Captures `candidate` on SET `valid` and returns it to the host, tagged, over a second valid/ready port.

---
 rtl/set_seq_pkg.sv | 34 +++
 rtl/set_job_fifo.sv | 64 ++++++
 rtl/set_job_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_set_job_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_seq_pkg.sv
// Shared types and constants for the SET job sequencer.
// The job tag width is a parameter of the top, so the tag travels next to
// set_job_t in the FIFO rather than inside the struct.
package set_seq_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned CAND_W    = 8;
  localparam int unsigned CENTRAL_W = 6 * COORD_W;
  localparam int unsigned RADIUS_W  = 3 * COORD_W;
  localparam int unsigned MODE_W    = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_A     = 2'b00;
  localparam mode_t MODE_UNION = 2'b01;
  localparam mode_t MODE_XOR   = 2'b10;
  localparam mode_t MODE_INTER = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    mode_t                mode;
  } set_job_t;

  localparam int unsigned JOB_W = $bits(set_job_t);

endpackage

// File: rtl/set_job_fifo.sv
// Small synchronous job FIFO. DEPTH must be a power of two so the pointers
// wrap naturally; the occupancy counter is one bit wider than the pointers.
module set_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("set_job_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/set_job_sequencer.sv
// Host-side wrapper for the SET circle-counting engine: queues jobs, issues
// them one at a time as a single-cycle en pulse, and returns tagged results.
// Optional watchdog on the WAIT state: define SET_SEQ_TIMEOUT_EN.
module set_job_sequencer
  import set_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CENTRAL_W-1:0] in_central,
  input  logic [RADIUS_W-1:0]  in_radius,
  input  logic [MODE_W-1:0]    in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CAND_W-1:0]    out_candidate,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("set_job_sequencer: TIMEOUT must be at least 1");
  end

  localparam int unsigned ENTRY_W = JOB_W + TAG_W;

  seq_state_t state_q, state_d;

  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  set_job_t           head_job;
  logic [TAG_W-1:0]   head_tag;

  set_job_t           job_q, job_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CAND_W-1:0]  cand_q, cand_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && !fifo_empty && !set_busy;
  assign fifo_din = {in_central, in_radius, mode_t'(in_mode), in_tag};
  assign {head_job, head_tag} = fifo_dout;

  set_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SET_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_hit;
  logic             err_q, err_d;

  // Counter value k means this is WAIT cycle k+1, so the last allowed
  // WAIT cycle is k == TIMEOUT-1.
  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign out_err     = err_q;

  // WAIT-cycle counter, cleared in ISSUE so it starts fresh on WAIT entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
`else
  assign out_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a valid on the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (set_valid) begin
          state_d = HOLD;
`ifdef SET_SEQ_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = HOLD;
`endif
        end
      end
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    set_en    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ISSUE:   set_en    = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Job and result next values: job loads on pop, result loads leaving WAIT.
  always_comb begin
    job_d  = job_q;
    tag_d  = tag_q;
    cand_d = cand_q;
`ifdef SET_SEQ_TIMEOUT_EN
    err_d  = err_q;
`endif
    if (pop) begin
      job_d = head_job;
      tag_d = head_tag;
    end
    if (state_q == WAIT) begin
      if (set_valid) begin
        cand_d = set_candidate;
`ifdef SET_SEQ_TIMEOUT_EN
        err_d  = 1'b0;
      end else if (timeout_hit) begin
        cand_d = '0;
        err_d  = 1'b1;
`endif
      end
    end
  end

  // Job and result registers; held between updates so SET and host see stable values.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_q  <= '{central: '0, radius: '0, mode: MODE_A};
      tag_q  <= '0;
      cand_q <= '0;
    end else begin
      job_q  <= job_d;
      tag_q  <= tag_d;
      cand_q <= cand_d;
    end
  end

  assign set_central   = job_q.central;
  assign set_radius    = job_q.radius;
  assign set_mode      = job_q.mode;
  assign out_candidate = cand_q;
  assign out_tag       = tag_q;

endmodule

// File: tb/tb_set_job_sequencer.sv
// Self-checking bench for set_job_sequencer with a behavioural SET stub.
module tb_set_job_sequencer;
  import set_seq_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_central;
  logic [11:0] in_radius;
  logic [1:0]  in_mode;
  logic [TAG_W-1:0] in_tag;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_candidate;
  logic [TAG_W-1:0] out_tag;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  set_job_sequencer #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_central    (in_central),
    .in_radius     (in_radius),
    .in_mode       (in_mode),
    .in_tag        (in_tag),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_candidate (out_candidate),
    .out_tag       (out_tag),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SET stub ----------------
  logic       stub_busy  = 1'b0;
  logic       stub_valid = 1'b0;
  logic [7:0] stub_cand  = 8'hEE;
  logic [7:0] stub_res   = 8'h00;
  int         stub_cnt   = 0;
  logic       stub_mute;
  logic       force_busy;

  assign set_busy      = stub_busy | force_busy;
  assign set_valid     = stub_valid;
  assign set_candidate = stub_cand;

  function automatic int sq(input int v);
    return v * v;
  endfunction

  // Counts grid points (1..8 x 1..8) selected by mode from circles A and B.
  function automatic logic [7:0] circle_count(input logic [23:0] c, input logic [11:0] r,
                                              input logic [1:0] m);
    int xa, ya, xb, yb, ra, rb, n;
    logic ina, inb, sel;
    xa = int'(c[23:20]); ya = int'(c[19:16]);
    xb = int'(c[15:12]); yb = int'(c[11:8]);
    ra = int'(r[11:8]);  rb = int'(r[7:4]);
    n = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        ina = (sq(x - xa) + sq(y - ya)) <= sq(ra);
        inb = (sq(x - xb) + sq(y - yb)) <= sq(rb);
        case (m)
          2'b00:   sel = ina;
          2'b01:   sel = ina | inb;
          2'b10:   sel = ina ^ inb;
          default: sel = ina & inb;
        endcase
        if (sel) n++;
      end
    end
    return 8'(n);
  endfunction

  // busy from the cycle after en through the valid cycle; valid 5 cycles after en.
  always @(posedge clk) begin
    if (stub_cnt == 0) begin
      stub_valid <= 1'b0;
      stub_cand  <= 8'hEE;
      if (set_en) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 1;
        stub_res  <= circle_count(set_central, set_radius, set_mode);
      end
    end else if (stub_cnt == 4) begin
      stub_valid <= !stub_mute;
      stub_cand  <= stub_mute ? 8'hEE : stub_res;
      stub_cnt   <= 5;
    end else if (stub_cnt == 5) begin
      stub_valid <= 1'b0;
      stub_cand  <= 8'hEE;
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input logic [TAG_W-1:0] t);
    int n;
    in_valid = 1'b1; in_central = c; in_radius = r; in_mode = m; in_tag = t;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    check("push_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_en(input int budget, output int cyc);
    cyc = 0;
    while (set_en !== 1'b1 && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    check("set_en_seen", {31'd0, set_en}, 32'd1);
  endtask

  task automatic wait_out(input int budget, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [7:0]       exp_cand;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc, en_cnt, ov_cnt;
    logic stable, ready_seen;
    logic [TAG_W-1:0] got_tag;

    vecs[0] = '{24'h440000, 12'h200, MODE_A,     6'd3,  8'h0D};
    vecs[1] = '{24'h110000, 12'h100, MODE_A,     6'd5,  8'h03};
    vecs[2] = '{24'h227700, 12'h000, MODE_UNION, 6'd7,  8'h02};
    vecs[3] = '{24'h445400, 12'h110, MODE_XOR,   6'd9,  8'h06};
    vecs[4] = '{24'h445400, 12'h110, MODE_INTER, 6'd10, 8'h02};
    vecs[5] = '{24'h440000, 12'h800, MODE_A,     6'd63, 8'h40};

    rst = 1'b1; in_valid = 1'b0; in_central = '0; in_radius = '0; in_mode = '0;
    in_tag = '0; out_ready = 1'b0; stub_mute = 1'b0; force_busy = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_set_en",    {31'd0, set_en},    32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    check("rst_out_cand",  {24'd0, out_candidate}, 32'd0);
    check("rst_out_tag",   {26'd0, out_tag},   32'd0);
    check("rst_central",   {8'd0, set_central}, 32'd0);
    check("rst_radius",    {20'd0, set_radius}, 32'd0);
    check("rst_mode",      {30'd0, set_mode},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single jobs
    for (int i = 0; i < 6; i++) begin
      push_job(vecs[i].central, vecs[i].radius, vecs[i].mode, vecs[i].tag);
      wait_en(20, cyc);
      if (i == 0) check("issue_latency", cyc, 32'd1);
      check("vec_set_central", {8'd0, set_central}, {8'd0, vecs[i].central});
      check("vec_set_radius",  {20'd0, set_radius}, {20'd0, vecs[i].radius});
      check("vec_set_mode",    {30'd0, set_mode},   {30'd0, vecs[i].mode});
      @(negedge clk);
      check("en_one_cycle",    {31'd0, set_en}, 32'd0);
      wait_out(40, cyc);
      if (i == 0) check("result_latency", cyc + 1, 32'd6);
      check("vec_out_cand", {24'd0, out_candidate}, {24'd0, vecs[i].exp_cand});
      check("vec_out_tag",  {26'd0, out_tag},       {26'd0, vecs[i].tag});
      check("vec_out_err",  {31'd0, out_err},       32'd0);
      handshake();
      check("vec_out_drop", {31'd0, out_valid}, 32'd0);
    end

    // Fill: 5 back-to-back pushes with SET stalled
    force_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_central = vecs[0].central; in_radius = vecs[0].radius;
      in_mode = vecs[0].mode; in_tag = TAG_W'(k);
      @(negedge clk);
    end
    check("fill_not_ready", {31'd0, in_ready}, 32'd0);
    in_tag = TAG_W'(4);
    en_cnt = 0; ready_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en_cnt += int'(set_en);
      ready_seen |= in_ready;
    end
    check("fill_no_en",    en_cnt, 32'd0);
    check("fill_held",     {31'd0, ready_seen}, 32'd0);
    force_busy = 1'b0;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    check("fill_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_out(40, cyc);
      check("fill_order_tag", {26'd0, out_tag}, k);
      check("fill_cand", {24'd0, out_candidate}, 32'h0D);
      handshake();
    end

    // Backpressure with a second job queued
    push_job(vecs[1].central, vecs[1].radius, vecs[1].mode, 6'd20);
    push_job(vecs[0].central, vecs[0].radius, vecs[0].mode, 6'd21);
    wait_out(40, cyc);
    stable = 1'b1; en_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      en_cnt += int'(set_en);
      if (out_valid !== 1'b1 || out_tag !== 6'd20 || out_candidate !== 8'h03 || out_err !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_no_en",  en_cnt, 32'd0);
    handshake();
    check("b2b_en_c1", {31'd0, set_en}, 32'd0);
    @(negedge clk);
    check("b2b_en_c2", {31'd0, set_en}, 32'd1);
    wait_out(40, cyc);
    check("bp_second_tag",  {26'd0, out_tag}, 32'd21);
    check("bp_second_cand", {24'd0, out_candidate}, 32'h0D);
    handshake();

    // Busy stall in IDLE
    force_busy = 1'b1;
    push_job(vecs[3].central, vecs[3].radius, vecs[3].mode, 6'd30);
    en_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); en_cnt += int'(set_en);
    end
    check("stall_no_en", en_cnt, 32'd0);
    force_busy = 1'b0;
    out_ready = 1'b1;
    en_cnt = 0; got_tag = '0; ov_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      en_cnt += int'(set_en);
      if (out_valid === 1'b1) begin
        got_tag = out_tag; ov_cnt++;
      end
    end
    out_ready = 1'b0;
    check("stall_one_en",   en_cnt, 32'd1);
    check("stall_one_out",  ov_cnt, 32'd1);
    check("stall_out_tag",  {26'd0, got_tag}, 32'd30);

    // Reset while a job is in WAIT and three are queued
    for (int k = 0; k < 4; k++)
      push_job(vecs[3].central, vecs[3].radius, vecs[3].mode, TAG_W'(40 + k));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mrst_set_en",    {31'd0, set_en},    32'd0);
    check("mrst_set_mode",  {30'd0, set_mode},  32'd0);
    check("mrst_out_tag",   {26'd0, out_tag},   32'd0);
    en_cnt = 0; ov_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      en_cnt += int'(set_en);
      ov_cnt += int'(out_valid);
    end
    check("mrst_no_issue",  en_cnt, 32'd0);
    check("mrst_no_result", ov_cnt, 32'd0);

    // WAIT with no valid from SET
    stub_mute = 1'b1;
    push_job(vecs[0].central, vecs[0].radius, vecs[0].mode, 6'd50);
    wait_en(20, cyc);
`ifdef SET_SEQ_TIMEOUT_EN
    wait_out(60, cyc);
    check("to_latency", cyc, TIMEOUT + 1);
    check("to_err",     {31'd0, out_err}, 32'd1);
    check("to_cand",    {24'd0, out_candidate}, 32'd0);
    check("to_tag",     {26'd0, out_tag}, 32'd50);
    handshake();
    check("to_done", {31'd0, out_valid}, 32'd0);
`else
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); ov_cnt += int'(out_valid);
    end
    check("nto_still_wait", ov_cnt, 32'd0);
    check("nto_err",        {31'd0, out_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("nto_rst_clear", {31'd0, out_valid}, 32'd0);
`endif
    stub_mute = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
